// File: rtl/led_pkg.sv
// Shared definitions for the LED step controller.
// Provides the run/pause state type, the speed width and type, and the
// default clock-divider and debounce constants used by the RTL.
package led_pkg;

    localparam int SPEED_W          = 2;
    localparam int DEF_BASE_DIV     = 4;
    localparam int DEF_DEBOUNCE_CYC = 4;

    typedef logic [SPEED_W-1:0] speed_t;

    typedef enum logic {
        RUN   = 1'b0,
        PAUSE = 1'b1
    } run_state_e;

endpackage

// File: rtl/led_step_ctrl_if.sv
// Signal bundle between the LED step controller and its environment.
//   btn_speed, btn_pause : raw push-buttons (to controller)
//   dir_sw               : raw direction slide switch (to controller)
//   step                 : single-clock advance pulse (from controller)
//   dir                  : direction qualifier, valid while step is high
//   speed                : current speed level, 0 slowest .. 3 fastest
//   running              : high in RUN, low in PAUSE
// master = the board/environment side, slave = the controller.
interface led_step_ctrl_if;

    logic            btn_speed;
    logic            btn_pause;
    logic            dir_sw;
    logic            step;
    logic            dir;
    led_pkg::speed_t speed;
    logic            running;

    modport master (
        output btn_speed, btn_pause, dir_sw,
        input  step, dir, speed, running
    );

    modport slave (
        input  btn_speed, btn_pause, dir_sw,
        output step, dir, speed, running
    );

endinterface

// File: rtl/led_debounce.sv
// Button conditioning: 2-flop synchroniser, debounce filter and rising-edge
// press detector.
//   clk     : system clock
//   reset   : asynchronous active-low reset
//   raw_i   : raw asynchronous button level
//   press_o : one-clock pulse on each accepted 0->1 transition
module led_debounce
    import led_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic press_o
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             meta_q;
    logic             sync_q;
    logic             level_q;
    logic             level_d;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: every register in an always_ff takes a non-blocking assignment so
    // all flops sample the values from before the edge, as real hardware does.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= raw_i;
            sync_q  <= meta_q;
            level_q <= level_d;
            prev_q  <= level_q;
            cnt_q   <= cnt_d;
        end
    end

    // Count consecutive clocks on which the synchronised input disagrees with
    // the accepted level; any agreement restarts the count, so a glitch
    // shorter than DEBOUNCE_CYC clocks never reaches the accepted level.
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign press_o = level_q & ~prev_q;

endmodule

// File: rtl/led_step_ctrl.sv
// Step-pulse generator for an 8-LED chaser.
//   clk   : system clock, all state updates on its rising edge
//   reset : asynchronous active-low reset
//   io    : slave side of led_step_ctrl_if (buttons, switch in; step, dir,
//           speed, running out)
// A prescaler emits one step every BASE_DIV * 2^(3-speed) clocks while in
// RUN. The speed button cycles the speed level and restarts the period; the
// pause button toggles RUN/PAUSE, with the prescaler frozen in PAUSE.
module led_step_ctrl
    import led_pkg::*;
#(
    parameter int BASE_DIV     = DEF_BASE_DIV,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic           clk,
    input  logic           reset,
    led_step_ctrl_if.slave io
);

    // Wide enough for the slowest period minus one: 8*BASE_DIV-1.
    localparam int CNT_W = $clog2(8 * BASE_DIV);
    typedef logic [CNT_W-1:0] cnt_t;

    logic       speed_ev;
    logic       pause_ev;
    logic       dir_meta_q;
    logic       dir_sync_q;
    run_state_e state_q;
    run_state_e state_d;
    cnt_t       cnt_q;
    cnt_t       cnt_d;
    cnt_t       cnt_last;
    speed_t     speed_q;
    speed_t     speed_d;
    logic       dir_q;
    logic       dir_d;
    logic       step_c;

    led_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_speed (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (io.btn_speed),
        .press_o (speed_ev)
    );

    led_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_pause (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (io.btn_pause),
        .press_o (pause_ev)
    );

    // The slide switch is only synchronised; it is sampled at step time, so
    // contact bounce between steps is harmless.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir_meta_q <= 1'b0;
            dir_sync_q <= 1'b0;
        end else begin
            dir_meta_q <= io.dir_sw;
            dir_sync_q <= dir_meta_q;
        end
    end

    always_comb begin
        case (speed_q)
            2'd0:    cnt_last = cnt_t'(8 * BASE_DIV - 1);
            2'd1:    cnt_last = cnt_t'(4 * BASE_DIV - 1);
            2'd2:    cnt_last = cnt_t'(2 * BASE_DIV - 1);
            default: cnt_last = cnt_t'(BASE_DIV - 1);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            speed_q <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            speed_q <= speed_d;
            dir_q   <= dir_d;
        end
    end

    // Counting is gated by the current state, so the clock carrying a pause
    // event still counts and the clock carrying the resume event does not.
    // A speed event takes priority over the prescaler: the period restarts
    // and no step is issued in that clock.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        speed_d = speed_q;
        dir_d   = dir_q;
        step_c  = 1'b0;

        if (pause_ev) begin
            state_d = (state_q == RUN) ? PAUSE : RUN;
        end

        if (speed_ev) begin
            speed_d = speed_q + 1'b1;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            if (cnt_q == cnt_last) begin
                step_c = 1'b1;
                cnt_d  = '0;
                dir_d  = dir_sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // During a step the freshly sampled direction is presented directly, and
    // the register keeps it steady until the next step.
    assign io.step    = step_c;
    assign io.dir     = step_c ? dir_sync_q : dir_q;
    assign io.speed   = speed_q;
    assign io.running = (state_q == RUN);

endmodule

// File: tb/tb_led_step_ctrl.sv
// Scoreboard bench for led_step_ctrl (BASE_DIV=4, DEBOUNCE_CYC=4).
// Each expected step carries its interval in clocks since the previous step
// (or since reset release), plus speed, dir and running during the pulse.
// Stimulus is issued right after a step pulse is seen, so a button press
// reaches the controller exactly 6 edges later; the hand-computed intervals
// below follow from that.
module tb_led_step_ctrl;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    led_step_ctrl_if bus ();

    led_step_ctrl #(
        .BASE_DIV     (4),
        .DEBOUNCE_CYC (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus)
    );

    typedef struct {
        int interval;
        int speed;
        int dir;
        int running;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    task automatic push(input int iv, input int sp, input int d, input int r);
        exp_t e;
        e.interval = iv;
        e.speed    = sp;
        e.dir      = d;
        e.running  = r;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Returns just after the negedge on which the last expected step was
    // consumed, i.e. still inside that step's clock.
    task automatic drain(input int limit);
        int k = 0;
        while (exp_q.size() != 0 && k < limit) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic press_speed();
        bus.btn_speed = 1'b1;
        tick(8);
        bus.btn_speed = 1'b0;
    endtask

    // Monitor: cyc counts clocks, the clock in which reset is released being
    // clock 1 of the first period, like the clock after a step pulse.
    always @(negedge clk) begin
        if (!reset) begin
            cyc = 1;
        end else begin
            cyc = cyc + 1;
            if (bus.step) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_step", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("step_interval", cyc, mon_e.interval);
                    check("step_speed", 32'(bus.speed), mon_e.speed);
                    check("step_dir", 32'(bus.dir), mon_e.dir);
                    check("step_running", 32'(bus.running), mon_e.running);
                end
                cyc = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b0;
        bus.btn_speed = 1'b0;
        bus.btn_pause = 1'b0;
        bus.dir_sw    = 1'b0;
        tick(3);
        check("rst_step", 32'(bus.step), 0);
        check("rst_dir", 32'(bus.dir), 0);
        check("rst_speed", 32'(bus.speed), 0);
        check("rst_running", 32'(bus.running), 1);

        // Free-running cadence at speed 0.
        reset = 1'b1;
        push(32, 0, 0, 1);
        push(32, 0, 0, 1);
        push(32, 0, 0, 1);
        drain(200);

        // Four speed presses: old period runs on until the event, then the
        // new period restarts from 0 six edges after the press.
        push(22, 1, 0, 1); push(16, 1, 0, 1); push(16, 1, 0, 1);
        press_speed();
        drain(200);
        push(14, 2, 0, 1); push(8, 2, 0, 1); push(8, 2, 0, 1);
        press_speed();
        drain(200);
        push(10, 3, 0, 1); push(4, 3, 0, 1); push(4, 3, 0, 1);
        press_speed();
        drain(200);
        push(4, 3, 0, 1); push(34, 0, 0, 1); push(32, 0, 0, 1);
        press_speed();
        drain(200);

        // 3-clock glitch: one short of the debounce length, must be ignored.
        push(32, 0, 0, 1);
        push(32, 0, 0, 1);
        bus.btn_speed = 1'b1;
        tick(3);
        bus.btn_speed = 1'b0;
        drain(200);
        check("glitch_speed", 32'(bus.speed), 0);

        // Pause for 50 clocks inside one period: that period stretches to 82.
        push(82, 0, 0, 1);
        tick(4);
        bus.btn_pause = 1'b1;
        tick(8);
        bus.btn_pause = 1'b0;
        tick(20);
        check("paused_running", 32'(bus.running), 0);
        check("paused_step", 32'(bus.step), 0);
        tick(22);
        bus.btn_pause = 1'b1;
        tick(8);
        bus.btn_pause = 1'b0;
        check("resumed_running", 32'(bus.running), 1);
        push(32, 0, 0, 1);
        drain(300);

        // Direction switch changes mid-period; dir follows only at the step.
        push(32, 0, 1, 1);
        tick(10);
        bus.dir_sw = 1'b1;
        tick(10);
        check("dir_hold_0", 32'(bus.dir), 0);
        drain(200);
        push(32, 0, 0, 1);
        tick(10);
        bus.dir_sw = 1'b0;
        tick(10);
        check("dir_hold_1", 32'(bus.dir), 1);
        drain(200);

        // Reach speed 2 with dir=1 latched, then reset mid-period.
        bus.dir_sw = 1'b1;
        push(22, 1, 1, 1); push(16, 1, 1, 1);
        press_speed();
        drain(200);
        push(14, 2, 1, 1); push(8, 2, 1, 1);
        press_speed();
        drain(200);
        tick(3);
        reset = 1'b0;
        #1;
        check("mid_rst_step", 32'(bus.step), 0);
        check("mid_rst_dir", 32'(bus.dir), 0);
        check("mid_rst_speed", 32'(bus.speed), 0);
        check("mid_rst_running", 32'(bus.running), 1);
        tick(3);
        reset = 1'b1;
        push(32, 0, 1, 1);
        push(32, 0, 1, 1);
        drain(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_step_ctrl.md
LED_STEP_CTRL -- requirements
Module: led_step_ctrl

Interface
REQ-001 SHALL have parameter BASE_DIV, default 4: clocks per step at fastest speed (>=2).
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 4: consecutive stable clocks needed to accept a button level (>=1).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port btn_speed  input  1  raw, asynchronous push-button; each accepted press selects the next speed.
REQ-006 SHALL have port btn_pause  input  1  raw, asynchronous push-button; each accepted press toggles run/pause.
REQ-007 SHALL have port dir_sw  input  1  raw slide switch; 0 = left-to-right, 1 = right-to-left.
REQ-008 SHALL have port step  output  1  single-clock pulse that advances the downstream 8-LED shifter by one position.
REQ-009 SHALL have port dir  output  1  direction qualifier, valid whenever step is high.
REQ-010 SHALL have port speed  output  2  current speed level, 0 = slowest, 3 = fastest.
REQ-011 SHALL have port running  output  1  high in RUN, low in PAUSE.

Function
REQ-012 SHALL pass each raw input through a 2-flop synchroniser before any other use.
REQ-013 SHALL debounce btn_speed and btn_pause: the debounced level follows the synchronised level only after it has differed for DEBOUNCE_CYC consecutive clocks; any shorter glitch is ignored.
REQ-014 SHALL generate a 1-clock press event on each 0->1 transition of a debounced button; release generates nothing.
REQ-015 SHALL use step period P = BASE_DIV * 2^(3-speed) clocks, giving 32/16/8/4 clocks at defaults.
REQ-016 SHALL, in RUN, increment a prescaler counter each clock and assert step in the clock where counter == P-1; in that same clock the counter wraps to 0.
REQ-017 SHALL implement FSM states RUN and PAUSE; a pause event toggles the state, and there are no other transitions.
REQ-018 SHALL, in PAUSE, hold the prescaler counter, keep step=0, and resume counting from the held value on return to RUN.
REQ-019 SHALL, on a speed event, set speed to speed+1 (3 wraps to 0) and clear the prescaler to 0 in the same clock; step is not asserted in that clock.
REQ-020 SHALL accept speed events in PAUSE: speed updates, the counter clears, and running stays 0.
REQ-021 SHALL apply both events in the same clock when pause and speed events coincide.
REQ-022 SHALL load dir from synchronised dir_sw only on clocks where step asserts, so dir never changes between steps.
REQ-023 SHALL keep the counter wide enough for 8*BASE_DIV-1, with no overflow at any speed.

Reset
REQ-024 SHALL, while reset is low, immediately force: step=0, dir=0, speed=0, running=1 (RUN), prescaler=0, synchronisers and debounced levels=0, edge detectors cleared.
REQ-025 SHALL, on reset assertion mid-period, discard partial counts; after release the first step comes exactly P(speed 0) clocks later.
REQ-026 SHALL treat a button held during reset release as pressed after debounce, generating one event.

Structure
REQ-027 SHALL place the state enum {RUN, PAUSE}, the speed width (2), and the default BASE_DIV/DEBOUNCE_CYC constants in shared package led_pkg.
REQ-028 SHALL implement synchroniser + debounce + rising-edge detect as sub-module led_debounce, instantiated twice; the dir_sw path uses a synchroniser only.

Verification
REQ-029 SHALL cover: reset released, no buttons -> first step after 32 clocks, then every 32 clocks, speed=0, running=1.
REQ-030 SHALL cover: four clean btn_speed presses -> periods 16, 8, 4, then back to 32; speed reads 1, 2, 3, 0.
REQ-031 SHALL cover: btn_pause pressed 10 clocks into a period, held paused 50 clocks, pressed again -> no step while paused; next step 22 clocks after resume.
REQ-032 SHALL cover: a 3-clock glitch on btn_speed -> speed unchanged, step cadence undisturbed.
REQ-033 SHALL cover: dir_sw toggled mid-period -> dir changes only at the next step pulse, never between steps.
REQ-034 SHALL cover: reset pulsed low mid-period at speed 2 -> outputs reach reset values immediately; first step 32 clocks after release.
